// File: rtl/convolution_3x3.sv
// rtl/convolution_3x3.sv - 3x3 per-channel RGB565 convolution with edge replication.
// Optional CONV_CLAMP_COUNT_EN adds a per-frame count of clamped output pixels.
module convolution_3x3 #(
    parameter int KERNEL_SIZE = 3,
    parameter int HRES        = 1280,
    parameter int VRES        = 720
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [KERNEL_SIZE-1:0][15:0] data_in,
    input  logic [10:0]                 h_count_in,
    input  logic [9:0]                  v_count_in,
    input  logic                        data_in_valid,
    input  logic [1:0]                  kernel_select,
    output logic [15:0]                 pixel_out,
    output logic [10:0]                 h_count_out,
    output logic [9:0]                  v_count_out,
`ifdef CONV_CLAMP_COUNT_EN
    output logic [15:0]                 clamp_count,
`endif
    output logic                        data_out_valid
);

    generate
        if (KERNEL_SIZE != 3 || HRES < 2 || HRES > 2048 || VRES < 1) begin : g_param_check
            $error("convolution_3x3: unsupported parameters");
        end
    endgenerate

    localparam logic [10:0] H_LAST = 11'(HRES - 1);

    function automatic logic signed [4:0] tap_weight(input logic [1:0] k, input int tap);
        logic signed [4:0] w;
        w = 5'sd0;
        case (k)
            2'd0:    w = (tap == 4) ? 5'sd1 : 5'sd0;
            2'd1:    w = (tap == 4) ? 5'sd4 : ((tap % 2) == 1) ? 5'sd2 : 5'sd1;
            2'd2:    w = (tap == 4) ? 5'sd5 : ((tap % 2) == 1) ? -5'sd1 : 5'sd0;
            default: w = (tap == 4) ? 5'sd8 : -5'sd1;
        endcase
        return w;
    endfunction

    function automatic logic [5:0] chan(input logic [15:0] p, input int ch);
        logic [5:0] c;
        case (ch)
            0:       c = {1'b0, p[15:11]};
            1:       c = p[10:5];
            default: c = {1'b0, p[4:0]};
        endcase
        return c;
    endfunction

    function automatic logic signed [11:0] mul(input logic signed [4:0] w, input logic [5:0] c);
        logic signed [11:0] pe;
        logic signed [11:0] we;
        pe = $signed({6'd0, c});
        we = {{7{w[4]}}, w};
        return pe * we;
    endfunction

    // Stage A: horizontal window and kernel latch
    logic [2:0][15:0]      w0, w1, w2;
    logic [2:0][2:0][15:0] win;
    logic                  a_valid;
    logic [10:0]           a_h;
    logic [9:0]            a_v;
    logic [1:0]            a_kernel;
    logic [1:0]            active_kernel;
    logic                  flush_pending;
    logic [9:0]            flush_v;
    logic                  frame_start;

    assign frame_start = data_in_valid && (h_count_in == 11'd0) && (v_count_in == 10'd0);
    assign win         = {w2, w1, w0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0            <= '0;
            w1            <= '0;
            w2            <= '0;
            a_valid       <= 1'b0;
            a_h           <= '0;
            a_v           <= '0;
            a_kernel      <= '0;
            active_kernel <= '0;
            flush_pending <= 1'b0;
            flush_v       <= '0;
        end else begin
            a_valid       <= 1'b0;
            flush_pending <= data_in_valid && (h_count_in == H_LAST);
            if (data_in_valid) flush_v <= v_count_in;
            if (frame_start) active_kernel <= kernel_select;
            // A real beat always wins over a pending flush
            if (data_in_valid) begin
                a_kernel <= frame_start ? kernel_select : active_kernel;
                a_v      <= v_count_in;
                if (h_count_in == 11'd0) begin
                    w1 <= data_in;
                    w2 <= data_in;
                end else begin
                    w0      <= w1;
                    w1      <= w2;
                    w2      <= data_in;
                    a_valid <= 1'b1;
                    a_h     <= h_count_in - 11'd1;
                end
            end else if (flush_pending) begin
                w0       <= w1;
                w1       <= w2;
                a_valid  <= 1'b1;
                a_h      <= H_LAST;
                a_v      <= flush_v;
                a_kernel <= active_kernel;
            end
        end
    end

    // Stage B: weighted products, tap index = row*3 + column
    logic signed [11:0] prod_d [3][9];
    logic signed [11:0] b_prod [3][9];
    logic               b_valid;
    logic [10:0]        b_h;
    logic [9:0]         b_v;
    logic [1:0]         b_kernel;

    always_comb begin
        for (int ch = 0; ch < 3; ch++)
            for (int t = 0; t < 9; t++)
                prod_d[ch][t] = mul(tap_weight(a_kernel, t), chan(win[t % 3][t / 3], ch));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 3; ch++)
                for (int t = 0; t < 9; t++)
                    b_prod[ch][t] <= '0;
            b_valid  <= 1'b0;
            b_h      <= '0;
            b_v      <= '0;
            b_kernel <= '0;
        end else begin
            b_prod   <= prod_d;
            b_valid  <= a_valid;
            b_h      <= a_h;
            b_v      <= a_v;
            b_kernel <= a_kernel;
        end
    end

    // Stage C: sum, normalise, clamp
    logic signed [11:0] c_sum;
    logic signed [11:0] c_max;
    logic [5:0]         c_res;
    logic [15:0]        pix_d;
    logic               clamp_d;

    always_comb begin
        pix_d   = '0;
        clamp_d = 1'b0;
        c_sum   = '0;
        c_max   = '0;
        c_res   = '0;
        for (int ch = 0; ch < 3; ch++) begin
            c_sum = '0;
            for (int t = 0; t < 9; t++)
                c_sum = c_sum + b_prod[ch][t];
            if (b_kernel == 2'd1) c_sum = c_sum >>> 4;
            c_max = (ch == 1) ? 12'sd63 : 12'sd31;
            if (c_sum < 0) begin
                c_res   = '0;
                clamp_d = 1'b1;
            end else if (c_sum > c_max) begin
                c_res   = c_max[5:0];
                clamp_d = 1'b1;
            end else begin
                c_res = c_sum[5:0];
            end
            case (ch)
                0:       pix_d[15:11] = c_res[4:0];
                1:       pix_d[10:5]  = c_res;
                default: pix_d[4:0]   = c_res[4:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out      <= '0;
            h_count_out    <= '0;
            v_count_out    <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= b_valid;
            if (b_valid) begin
                pixel_out   <= pix_d;
                h_count_out <= b_h;
                v_count_out <= b_v;
            end
        end
    end

`ifdef CONV_CLAMP_COUNT_EN
    // Frame-start output beat restarts the count and is itself counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clamp_count <= '0;
        end else if (b_valid) begin
            if (b_h == 11'd0 && b_v == 10'd0)
                clamp_count <= {15'd0, clamp_d};
            else if (clamp_d && clamp_count != 16'hFFFF)
                clamp_count <= clamp_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_convolution_3x3.sv
// tb/tb_convolution_3x3.sv - directed self-checking bench for convolution_3x3.
module tb_convolution_3x3;

    localparam int HRES = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0][15:0] data_in = '0;
    logic [10:0]      h_count_in = '0;
    logic [9:0]       v_count_in = '0;
    logic             data_in_valid = 1'b0;
    logic [1:0]       kernel_select = '0;
    logic [15:0]      pixel_out;
    logic [10:0]      h_count_out;
    logic [9:0]       v_count_out;
    logic             data_out_valid;
`ifdef CONV_CLAMP_COUNT_EN
    logic [15:0]      clamp_count;
`endif

    convolution_3x3 #(.KERNEL_SIZE(3), .HRES(HRES), .VRES(720)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .h_count_in     (h_count_in),
        .v_count_in     (v_count_in),
        .data_in_valid  (data_in_valid),
        .kernel_select  (kernel_select),
        .pixel_out      (pixel_out),
        .h_count_out    (h_count_out),
        .v_count_out    (v_count_out),
`ifdef CONV_CLAMP_COUNT_EN
        .clamp_count    (clamp_count),
`endif
        .data_out_valid (data_out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] q_pix[$];
    int          q_h[$];
    int          q_v[$];
    int          q_cyc[$];

    always @(negedge clk) begin
        if (data_out_valid) begin
            q_pix.push_back(pixel_out);
            q_h.push_back(int'(h_count_out));
            q_v.push_back(int'(v_count_out));
            q_cyc.push_back(cyc);
        end
    end

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] row_t[HRES];
    logic [15:0] row_c[HRES];
    logic [15:0] row_b[HRES];
    logic [15:0] exp_pix[HRES];
    int          beat_cyc[HRES];
    int          flush_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        q_pix.delete();
        q_h.delete();
        q_v.delete();
        q_cyc.delete();
    endtask

    task automatic set_rows(input logic [15:0] t, input logic [15:0] c, input logic [15:0] b);
        for (int h = 0; h < HRES; h++) begin
            row_t[h] = t;
            row_c[h] = c;
            row_b[h] = b;
        end
    endtask

    task automatic drive_beat(input int h, input int v, input int k);
        data_in[0]    = row_t[h];
        data_in[1]    = row_c[h];
        data_in[2]    = row_b[h];
        h_count_in    = 11'(h);
        v_count_in    = 10'(v);
        kernel_select = 2'(k);
        data_in_valid = 1'b1;
    endtask

    task automatic send_line(input int v, input int k, input bit back_to_back);
        for (int h = 0; h < HRES; h++) begin
            @(negedge clk);
            drive_beat(h, v, k);
            beat_cyc[h] = cyc;
        end
        if (!back_to_back) begin
            @(negedge clk);
            data_in_valid = 1'b0;
            flush_cyc = cyc;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic find_out(input int v, input int h, output bit found,
                            output logic [15:0] pix, output int oc);
        found = 1'b0;
        pix   = '0;
        oc    = 0;
        for (int i = 0; i < q_pix.size(); i++) begin
            if (q_v[i] == v && q_h[i] == h) begin
                found = 1'b1;
                pix   = q_pix[i];
                oc    = q_cyc[i];
            end
        end
    endtask

    function automatic int count_v(input int v);
        int n = 0;
        for (int i = 0; i < q_v.size(); i++)
            if (q_v[i] == v) n++;
        return n;
    endfunction

    task automatic expect_line(input string tag, input int v, input bit lat);
        bit          found;
        logic [15:0] pix;
        int          oc;
        check($sformatf("%s count", tag), 32'(count_v(v)), 32'(HRES));
        for (int h = 0; h < HRES; h++) begin
            find_out(v, h, found, pix, oc);
            check($sformatf("%s h%0d present", tag, h), {31'd0, found}, 32'd1);
            if (found) begin
                check($sformatf("%s h%0d pix", tag, h), {16'd0, pix}, {16'd0, exp_pix[h]});
                if (lat)
                    check($sformatf("%s h%0d latency", tag, h), 32'(oc),
                          32'((h < HRES - 1) ? beat_cyc[h + 1] + 3 : flush_cyc + 3));
            end
        end
    endtask

    initial begin
        bit          found;
        logic [15:0] pix;
        int          oc;

        repeat (2) @(negedge clk);
        check("reset valid", {31'd0, data_out_valid}, 32'd0);
        check("reset pixel", {16'd0, pixel_out}, 32'd0);
        check("reset hcount", {21'd0, h_count_out}, 32'd0);
`ifdef CONV_CLAMP_COUNT_EN
        check("reset clamp_count", {16'd0, clamp_count}, 32'd0);
`endif
        rst_n = 1'b1;

        // Identity ramp, then a mid-frame kernel change that must be ignored
        set_rows(16'h0841, 16'h0000, 16'hF800);
        for (int h = 0; h < HRES; h++) begin
            row_c[h]   = 16'(h);
            exp_pix[h] = 16'(h);
        end
        clear_q();
        send_line(0, 0, 1'b0);
        expect_line("identity", 0, 1'b1);
        send_line(1, 3, 1'b0);
        expect_line("latch hold", 1, 1'b0);

        // Gaussian flat field
        set_rows(16'hFFFF, 16'hFFFF, 16'hFFFF);
        for (int h = 0; h < HRES; h++) exp_pix[h] = 16'hFFFF;
        clear_q();
        send_line(0, 1, 1'b0);
        expect_line("gauss flat", 0, 1'b0);

        // Gaussian point: R=16 in centre row, then in top row (kernel_select ignored mid-frame)
        set_rows(16'h0000, 16'h0000, 16'h0000);
        row_c[3] = 16'h8000;
        for (int h = 0; h < HRES; h++) exp_pix[h] = 16'h0000;
        exp_pix[2] = 16'h1000;
        exp_pix[3] = 16'h2000;
        exp_pix[4] = 16'h1000;
        clear_q();
        send_line(0, 1, 1'b0);
        expect_line("gauss point mid", 0, 1'b0);
        set_rows(16'h0000, 16'h0000, 16'h0000);
        row_t[3] = 16'h8000;
        exp_pix[2] = 16'h0800;
        exp_pix[3] = 16'h1000;
        exp_pix[4] = 16'h0800;
        clear_q();
        send_line(1, 0, 1'b0);
        expect_line("gauss point top", 1, 1'b0);

        // Sharpen clamping high and low
        set_rows(16'h0000, 16'h0000, 16'h0000);
        row_c[3] = 16'hFFFF;
        for (int h = 0; h < HRES; h++) exp_pix[h] = 16'h0000;
        exp_pix[3] = 16'hFFFF;
        clear_q();
        send_line(0, 2, 1'b0);
        expect_line("sharpen high", 0, 1'b0);
        set_rows(16'hFFFF, 16'hFFFF, 16'hFFFF);
        row_c[3] = 16'h0000;
        for (int h = 0; h < HRES; h++) exp_pix[h] = 16'hFFFF;
        exp_pix[3] = 16'h0000;
        clear_q();
        send_line(1, 2, 1'b0);
        expect_line("sharpen low", 1, 1'b0);
`ifdef CONV_CLAMP_COUNT_EN
        check("clamp_count sharpen", {16'd0, clamp_count}, 32'd6);
`endif

        // Laplacian with a green column at the left edge
        set_rows(16'h0000, 16'h0000, 16'h0000);
        row_t[0] = 16'h07E0;
        row_c[0] = 16'h07E0;
        row_b[0] = 16'h07E0;
        for (int h = 0; h < HRES; h++) exp_pix[h] = 16'h0000;
        exp_pix[0] = 16'h07E0;
        clear_q();
        send_line(0, 3, 1'b0);
        expect_line("laplace edge", 0, 1'b0);
`ifdef CONV_CLAMP_COUNT_EN
        check("clamp_count new frame", {16'd0, clamp_count}, 32'd2);
`endif

        // h=0 arriving in the flush cycle drops the last column of the old line
        set_rows(16'h1234, 16'h0000, 16'h4321);
        for (int h = 0; h < HRES; h++) begin
            row_c[h]   = 16'h0100 + 16'(h);
            exp_pix[h] = 16'h0100 + 16'(h);
        end
        clear_q();
        send_line(0, 0, 1'b1);
        send_line(1, 0, 1'b0);
        check("flush drop count", 32'(count_v(0)), 32'(HRES - 1));
        find_out(0, HRES - 1, found, pix, oc);
        check("flush drop absent", {31'd0, found}, 32'd0);
        find_out(0, 6, found, pix, oc);
        check("flush drop h6", {16'd0, pix}, 32'h0106);
        expect_line("after drop", 1, 1'b0);

        // Asynchronous reset mid-line
        set_rows(16'hFFFF, 16'h0000, 16'hFFFF);
        for (int h = 0; h < HRES; h++) row_c[h] = 16'h0200 + 16'(h);
        clear_q();
        for (int h = 0; h < 6; h++) begin
            @(negedge clk);
            drive_beat(h, 2, 0);
        end
        check("pre-reset valid", {31'd0, data_out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        data_in_valid = 1'b0;
        #1;
        check("async reset valid", {31'd0, data_out_valid}, 32'd0);
        check("async reset pixel", {16'd0, pixel_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        repeat (5) @(negedge clk);
        check("no output after reset", 32'(q_pix.size()), 32'd0);
        @(negedge clk);
        drive_beat(0, 5, 3);
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("no output after h0", 32'(q_pix.size()), 32'd0);
        @(negedge clk);
        drive_beat(1, 5, 3);
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("output after h1", 32'(q_pix.size()), 32'd1);
        if (q_pix.size() == 1) begin
            check("post-reset identity pix", {16'd0, q_pix[0]}, 32'h0200);
            check("post-reset h", 32'(q_h[0]), 32'd0);
            check("post-reset v", 32'(q_v[0]), 32'd5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
